// File: rtl/icache_fill_ctrl.sv
// Icache miss/fill controller: fetch hits pass straight through the array, and a miss issues one BUS_LOAD and writes the returned line.
// Latency: a hit is combinational (0 cycles). A miss issues BUS_LOAD the cycle after detection, and the fill write happens in the data-return cycle.
// Backpressure: BUS_LOAD is re-issued until memory returns a nonzero response tag. Only one fill is outstanding at a time.
// Optional: define ICACHE_STATS_EN to add the miss_count / fill_cycles saturating counters.
module icache_fill_ctrl #(
  parameter int IDX_BITS     = 7,
  parameter int TAG_BITS     = 54,
  parameter int MEM_TAG_BITS = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [63:0]             proc2Icache_addr,
  output logic [63:0]             Icache_data_out,
  output logic                    Icache_valid_out,
  input  logic [63:0]             cachemem_data,
  input  logic                    cachemem_valid,
  output logic [IDX_BITS-1:0]     current_index,
  output logic [TAG_BITS-1:0]     current_tag,
  output logic [1:0]              proc2Imem_command,
  output logic [63:0]             proc2Imem_addr,
  input  logic [MEM_TAG_BITS-1:0] Imem2proc_response,
  input  logic [63:0]             Imem2proc_data,
  input  logic [MEM_TAG_BITS-1:0] Imem2proc_tag,
  output logic                    fill_wr_en,
  output logic [IDX_BITS-1:0]     fill_wr_idx,
  output logic [TAG_BITS-1:0]     fill_wr_tag,
  output logic [63:0]             fill_wr_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]             miss_count,
  output logic [31:0]             fill_cycles
`endif
);

  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t                  r_state;
  logic [MEM_TAG_BITS-1:0] r_pending_tag;
  logic [IDX_BITS-1:0]     r_idx;
  logic [TAG_BITS-1:0]     r_tag;

  logic [IDX_BITS-1:0]     w_idx;
  logic [TAG_BITS-1:0]     w_tag;
  logic                    w_addr_chg;
  logic                    w_req_live;
  logic                    w_fill_hit;
  logic                    w_unused_ok;

  // The line offset bits never reach the array.
  assign w_unused_ok = ^proc2Icache_addr[2:0];

  assign w_idx = proc2Icache_addr[IDX_BITS+2:3];
  assign w_tag = proc2Icache_addr[63:IDX_BITS+3];

  assign current_index = w_idx;
  assign current_tag   = w_tag;

  assign Icache_data_out  = cachemem_data;
  assign Icache_valid_out = cachemem_valid && !reset;

  // A redirect while requesting makes the latched line stale. The request is withheld in that cycle so memory never accepts it.
  assign w_addr_chg = (w_idx != r_idx) || (w_tag != r_tag);
  assign w_req_live = (r_state == REQ) && !w_addr_chg;

  assign proc2Imem_command = w_req_live ? BUS_LOAD : BUS_NONE;
  assign proc2Imem_addr    = w_req_live ? {r_tag, r_idx, 3'b000} : 64'd0;

  // pending_tag is zero whenever nothing is outstanding, so a tag-0 data beat or a late post-reset return cannot match.
  assign w_fill_hit = (r_state == WAIT) && (r_pending_tag != '0) &&
                      (Imem2proc_tag == r_pending_tag);

  assign fill_wr_en   = w_fill_hit;
  assign fill_wr_idx  = r_idx;
  assign fill_wr_tag  = r_tag;
  assign fill_wr_data = Imem2proc_data;

  // Miss/fill sequencer: latch the missing line, request until accepted, then wait for the matching data tag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_pending_tag <= '0;
      r_idx         <= '0;
      r_tag         <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!cachemem_valid) begin
            r_idx   <= w_idx;
            r_tag   <= w_tag;
            r_state <= REQ;
          end
        end
        REQ: begin
          if (w_addr_chg) begin
            r_idx <= w_idx;
            r_tag <= w_tag;
            if (cachemem_valid) begin
              r_state <= IDLE;
            end
          end else if (Imem2proc_response != '0) begin
            r_pending_tag <= Imem2proc_response;
            r_state       <= WAIT;
          end
        end
        WAIT: begin
          if (w_fill_hit) begin
            r_pending_tag <= '0;
            r_state       <= IDLE;
          end
        end
        default: begin
          r_state       <= IDLE;
          r_pending_tag <= '0;
        end
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  // Saturating counters: the number of misses started, and the number of cycles spent outside IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      miss_count  <= '0;
      fill_cycles <= '0;
    end else begin
      if ((r_state == IDLE) && !cachemem_valid && (miss_count != 32'hFFFF_FFFF)) begin
        miss_count <= miss_count + 32'd1;
      end
      if ((r_state != IDLE) && (fill_cycles != 32'hFFFF_FFFF)) begin
        fill_cycles <= fill_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed bench for icache_fill_ctrl. The expected values are hand-computed from the behaviour of the fill controller.
// Inputs are driven 1 time unit after the rising edge. Outputs are compared 1 time unit later, which keeps sampling well away from the edge.
module tb_icache_fill_ctrl;

  logic        clock;
  logic        reset;
  logic [63:0] proc2Icache_addr;
  logic [63:0] Icache_data_out;
  logic        Icache_valid_out;
  logic [63:0] cachemem_data;
  logic        cachemem_valid;
  logic [6:0]  current_index;
  logic [53:0] current_tag;
  logic [1:0]  proc2Imem_command;
  logic [63:0] proc2Imem_addr;
  logic [3:0]  Imem2proc_response;
  logic [63:0] Imem2proc_data;
  logic [3:0]  Imem2proc_tag;
  logic        fill_wr_en;
  logic [6:0]  fill_wr_idx;
  logic [53:0] fill_wr_tag;
  logic [63:0] fill_wr_data;
`ifdef ICACHE_STATS_EN
  logic [31:0] miss_count;
  logic [31:0] fill_cycles;
`endif

  int n_checks;
  int n_fail;

  icache_fill_ctrl dut (
    .clock              (clock),
    .reset              (reset),
    .proc2Icache_addr   (proc2Icache_addr),
    .Icache_data_out    (Icache_data_out),
    .Icache_valid_out   (Icache_valid_out),
    .cachemem_data      (cachemem_data),
    .cachemem_valid     (cachemem_valid),
    .current_index      (current_index),
    .current_tag        (current_tag),
    .proc2Imem_command  (proc2Imem_command),
    .proc2Imem_addr     (proc2Imem_addr),
    .Imem2proc_response (Imem2proc_response),
    .Imem2proc_data     (Imem2proc_data),
    .Imem2proc_tag      (Imem2proc_tag),
    .fill_wr_en         (fill_wr_en),
    .fill_wr_idx        (fill_wr_idx),
    .fill_wr_tag        (fill_wr_tag),
    .fill_wr_data       (fill_wr_data)
`ifdef ICACHE_STATS_EN
    ,
    .miss_count         (miss_count),
    .fill_cycles        (fill_cycles)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance to the drive point of the next cycle.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Let combinational outputs settle before comparing.
  task automatic settle();
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset              = 1'b1;
    proc2Icache_addr   = 64'h100;
    cachemem_data      = 64'h0;
    cachemem_valid     = 1'b1;
    Imem2proc_response = 4'd0;
    Imem2proc_data     = 64'h0;
    Imem2proc_tag      = 4'd0;
    #2;
    chk("rst_cmd",   {62'd0, proc2Imem_command}, 64'd0);
    chk("rst_addr",  proc2Imem_addr, 64'd0);
    chk("rst_wren",  {63'd0, fill_wr_en}, 64'd0);
    chk("rst_valid", {63'd0, Icache_valid_out}, 64'd0);
    cyc();
    cyc();

    // Cold miss on 0x100 (cycle 0 = the first cycle out of reset).
    reset          = 1'b0;
    cachemem_valid = 1'b0;
    settle();
    chk("cold_idx", {57'd0, current_index}, 64'h20);
    chk("cold_tag", {10'd0, current_tag}, 64'h0);
    chk("cold_c0_cmd", {62'd0, proc2Imem_command}, 64'd0);
    cyc();
    settle();
    chk("cold_c1_cmd",  {62'd0, proc2Imem_command}, 64'd1);
    chk("cold_c1_addr", proc2Imem_addr, 64'h100);
    cyc();
    Imem2proc_response = 4'd3;
    settle();
    chk("cold_c2_cmd",  {62'd0, proc2Imem_command}, 64'd1);
    chk("cold_c2_addr", proc2Imem_addr, 64'h100);
    for (int c = 3; c <= 5; c++) begin
      cyc();
      Imem2proc_response = 4'd0;
      settle();
      chk("cold_wait_cmd",  {62'd0, proc2Imem_command}, 64'd0);
      chk("cold_wait_wren", {63'd0, fill_wr_en}, 64'd0);
    end
    cyc();
    Imem2proc_tag  = 4'd3;
    Imem2proc_data = 64'hCAFE;
    settle();
    chk("cold_fill_en",    {63'd0, fill_wr_en}, 64'd1);
    chk("cold_fill_idx",   {57'd0, fill_wr_idx}, 64'h20);
    chk("cold_fill_tag",   {10'd0, fill_wr_tag}, 64'h0);
    chk("cold_fill_data",  fill_wr_data, 64'hCAFE);
    chk("cold_fill_valid", {63'd0, Icache_valid_out}, 64'd0);
    cyc();
    Imem2proc_tag  = 4'd0;
    cachemem_valid = 1'b1;
    settle();
    chk("cold_done_wren", {63'd0, fill_wr_en}, 64'd0);
    chk("cold_done_cmd",  {62'd0, proc2Imem_command}, 64'd0);

    // Hit on 0x208.
    proc2Icache_addr = 64'h208;
    cachemem_data    = 64'hDEAD;
    settle();
    chk("hit_valid", {63'd0, Icache_valid_out}, 64'd1);
    chk("hit_data",  Icache_data_out, 64'hDEAD);
    chk("hit_idx",   {57'd0, current_index}, 64'h41);
    chk("hit_cmd",   {62'd0, proc2Imem_command}, 64'd0);
    cyc();
    settle();
    chk("hit_cmd2", {62'd0, proc2Imem_command}, 64'd0);

    // Bus busy: 0x1000 gives idx 0 and tag 4. Five refusals, then the response takes tag 9 with same-tag data in that cycle.
    proc2Icache_addr = 64'h1000;
    cachemem_valid   = 1'b0;
    cyc();
    for (int c = 0; c < 5; c++) begin
      settle();
      chk("busy_cmd",  {62'd0, proc2Imem_command}, 64'd1);
      chk("busy_addr", proc2Imem_addr, 64'h1000);
      cyc();
    end
    Imem2proc_response = 4'd9;
    Imem2proc_tag      = 4'd9;
    Imem2proc_data     = 64'h9999;
    settle();
    chk("busy_acc_cmd",  {62'd0, proc2Imem_command}, 64'd1);
    chk("busy_acc_addr", proc2Imem_addr, 64'h1000);
    chk("busy_same_tag_wren", {63'd0, fill_wr_en}, 64'd0);
    cyc();
    Imem2proc_response = 4'd0;
    Imem2proc_tag      = 4'd5;
    Imem2proc_data     = 64'h5555;
    settle();
    chk("busy_tag5_wren", {63'd0, fill_wr_en}, 64'd0);
    chk("busy_wait_cmd",  {62'd0, proc2Imem_command}, 64'd0);
    cyc();
    Imem2proc_tag  = 4'd9;
    Imem2proc_data = 64'h99;
    settle();
    chk("busy_fill_en",   {63'd0, fill_wr_en}, 64'd1);
    chk("busy_fill_idx",  {57'd0, fill_wr_idx}, 64'h0);
    chk("busy_fill_tag",  {10'd0, fill_wr_tag}, 64'h4);
    chk("busy_fill_data", fill_wr_data, 64'h99);
    cyc();
    Imem2proc_tag  = 4'd0;
    cachemem_valid = 1'b1;
    settle();
    chk("busy_done_wren", {63'd0, fill_wr_en}, 64'd0);

    // Redirect during WAIT: the line for 0x100 must still fill, and 0x400 is requested only afterwards.
    proc2Icache_addr = 64'h100;
    cachemem_valid   = 1'b0;
    cyc();
    Imem2proc_response = 4'd2;
    settle();
    chk("redir_req_cmd",  {62'd0, proc2Imem_command}, 64'd1);
    chk("redir_req_addr", proc2Imem_addr, 64'h100);
    cyc();
    Imem2proc_response = 4'd0;
    proc2Icache_addr   = 64'h400;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("redir_wait_cmd",  {62'd0, proc2Imem_command}, 64'd0);
      chk("redir_wait_wren", {63'd0, fill_wr_en}, 64'd0);
      cyc();
    end
    Imem2proc_tag  = 4'd2;
    Imem2proc_data = 64'h2222;
    settle();
    chk("redir_fill_en",  {63'd0, fill_wr_en}, 64'd1);
    chk("redir_fill_idx", {57'd0, fill_wr_idx}, 64'h20);
    chk("redir_fill_tag", {10'd0, fill_wr_tag}, 64'h0);
    cyc();
    Imem2proc_tag = 4'd0;
    settle();
    chk("redir_idle_cmd", {62'd0, proc2Imem_command}, 64'd0);
    cyc();
    settle();
    chk("redir_new_cmd",  {62'd0, proc2Imem_command}, 64'd1);
    chk("redir_new_addr", proc2Imem_addr, 64'h400);

    // Asynchronous reset between edges while requesting.
    #2;
    reset = 1'b1;
    #1;
    chk("areq_cmd",  {62'd0, proc2Imem_command}, 64'd0);
    chk("areq_addr", proc2Imem_addr, 64'd0);
    cyc();
    reset = 1'b0;
    cyc();
    Imem2proc_response = 4'd6;
    settle();
    chk("await_req_cmd", {62'd0, proc2Imem_command}, 64'd1);
    cyc();
    Imem2proc_response = 4'd0;
    // Asynchronous reset between edges while waiting for tag 6. The late return must not write.
    #2;
    reset         = 1'b1;
    Imem2proc_tag = 4'd6;
    #1;
    chk("await_rst_cmd",  {62'd0, proc2Imem_command}, 64'd0);
    chk("await_rst_wren", {63'd0, fill_wr_en}, 64'd0);
    cyc();
    reset          = 1'b0;
    cachemem_valid = 1'b1;
    settle();
    chk("await_late_wren", {63'd0, fill_wr_en}, 64'd0);
    cyc();
    settle();
    chk("await_late_wren2", {63'd0, fill_wr_en}, 64'd0);
    chk("await_late_cmd",   {62'd0, proc2Imem_command}, 64'd0);
    Imem2proc_tag = 4'd0;

`ifdef ICACHE_STATS_EN
    // Three misses, each with 1 REQ cycle and 1 WAIT cycle, give 6 non-IDLE cycles.
    #2;
    reset = 1'b1;
    #1;
    chk("stats_rst_miss", {32'd0, miss_count}, 64'd0);
    chk("stats_rst_fill", {32'd0, fill_cycles}, 64'd0);
    cyc();
    reset = 1'b0;
    for (int m = 1; m <= 3; m++) begin
      proc2Icache_addr = 64'h1000 + 64'(m) * 64'h8;
      cachemem_valid   = 1'b0;
      cyc();
      Imem2proc_response = 4'(m);
      cyc();
      Imem2proc_response = 4'd0;
      Imem2proc_tag      = 4'(m);
      settle();
      chk("stats_fill_en", {63'd0, fill_wr_en}, 64'd1);
      cyc();
      Imem2proc_tag = 4'd0;
    end
    cachemem_valid = 1'b1;
    cyc();
    settle();
    chk("stats_miss_count",  {32'd0, miss_count}, 64'd3);
    chk("stats_fill_cycles", {32'd0, fill_cycles}, 64'd6);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
